// File: rtl/packet_router_pkg.sv
// Shared types for the packet router / arbiter slice.
// Arbiter FSM states, input count and stream-ID type.
package packet_router_pkg;

    localparam int NUM_ARB_INPUTS = 2;

    typedef enum logic [1:0] {
        IDLE,
        GRANT0,
        GRANT1,
        DRAIN
    } arb_state_t;

    typedef logic [$clog2(NUM_ARB_INPUTS)-1:0] tid_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered output stage: all outputs come from flops,
// and upstream ready depends only on occupancy, never on o_ready.
module axis_skid_buffer #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready_up,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready_dn
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic         r_head_vld;
    logic         r_tail_vld;
    logic         w_push;
    logic         w_pop;

    assign o_ready_up = ~r_tail_vld;
    assign o_data     = r_head;
    assign o_valid    = r_head_vld;
    assign w_push     = i_valid & ~r_tail_vld;
    assign w_pop      = r_head_vld & i_ready_dn;

    // Head is the output register; tail only fills when head is stalled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_head_vld <= 1'b0;
            r_tail_vld <= 1'b0;
        end else if (w_push) begin
            if (!r_head_vld || w_pop) begin
                r_head     <= i_data;
                r_head_vld <= 1'b1;
            end else begin
                r_tail     <= i_data;
                r_tail_vld <= 1'b1;
            end
        end else if (w_pop) begin
            if (r_tail_vld) begin
                r_head     <= r_tail;
                r_tail_vld <= 1'b0;
            end else begin
                r_head_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-atomic round-robin merge of two AXI-Stream inputs.
// Optional max-length truncation: define PKT_ARB_MAXLEN_EN.
module axis_packet_arbiter
    import packet_router_pkg::*;
#(
    parameter int TDATA_WIDTH = 32,
    parameter int MAX_BEATS   = 256
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [TDATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                   s0_axis_tlast,
    input  logic                   s0_axis_tvalid,
    output logic                   s0_axis_tready,
    input  logic [TDATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                   s1_axis_tlast,
    input  logic                   s1_axis_tvalid,
    output logic                   s1_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic [0:0]             m_axis_tid,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready
);

    localparam int SB_W = TDATA_WIDTH + 2;

    if ((TDATA_WIDTH != 32 && TDATA_WIDTH != 64 &&
         TDATA_WIDTH != 128 && TDATA_WIDTH != 256) ||
        MAX_BEATS < 2) begin : g_param_check
        $error("axis_packet_arbiter: illegal parameter value");
    end

    arb_state_t             r_state;
    arb_state_t             w_next;
    tid_t                   r_last_grant;
    logic                   w_sel_valid;
    logic                   w_sel_last;
    logic                   w_sel_ready;
    logic                   w_push;
    logic                   w_push_last;
    logic                   w_sb_ready;
    logic [TDATA_WIDTH-1:0] w_sel_data;
    logic [SB_W-1:0]        w_sb_in;
    logic [SB_W-1:0]        w_sb_out;

`ifdef PKT_ARB_MAXLEN_EN
    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    logic [CNT_W-1:0] r_beats;
    logic             w_trunc;

    assign w_trunc = ~w_sel_last &
                     (r_beats == CNT_W'(MAX_BEATS - 1));
`endif

    // r_last_grant doubles as the current owner while granted
    assign w_sel_valid = r_last_grant[0] ? s1_axis_tvalid : s0_axis_tvalid;
    assign w_sel_last  = r_last_grant[0] ? s1_axis_tlast  : s0_axis_tlast;
    assign w_sel_data  = r_last_grant[0] ? s1_axis_tdata  : s0_axis_tdata;

    assign s0_axis_tready = w_sel_ready & ~r_last_grant[0];
    assign s1_axis_tready = w_sel_ready &  r_last_grant[0];

    assign w_sb_in = {w_sel_data, w_push_last, r_last_grant};

    // Arbiter state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Next state, input ready and push control
    always_comb begin
        w_next      = r_state;
        w_sel_ready = 1'b0;
        w_push      = 1'b0;
        w_push_last = w_sel_last;
        unique case (r_state)
            IDLE: begin
                if (s0_axis_tvalid &&
                    (!s1_axis_tvalid || r_last_grant == 1'b1))
                    w_next = GRANT0;
                else if (s1_axis_tvalid)
                    w_next = GRANT1;
            end
            GRANT0, GRANT1: begin
                w_sel_ready = w_sb_ready;
                w_push      = w_sel_valid & w_sb_ready;
`ifdef PKT_ARB_MAXLEN_EN
                if (w_push && w_trunc) begin
                    w_push_last = 1'b1;
                    w_next      = DRAIN;
                end else if (w_push && w_sel_last) begin
                    w_next = IDLE;
                end
`else
                if (w_push && w_sel_last)
                    w_next = IDLE;
`endif
            end
            DRAIN: begin
                w_sel_ready = 1'b1;
                if (w_sel_valid && w_sel_last)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Round-robin pointer, updated when a grant is issued
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_last_grant <= 1'b1;
        else if (r_state == IDLE && w_next != IDLE)
            r_last_grant <= (w_next == GRANT1);
    end

`ifdef PKT_ARB_MAXLEN_EN
    // Beats forwarded in the current packet
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_beats <= '0;
        else if (r_state == IDLE)
            r_beats <= '0;
        else if (w_push)
            r_beats <= r_beats + 1'b1;
    end
`endif

    axis_skid_buffer #(
        .W (SB_W)
    ) u_skid (
        .clk        (clk),
        .resetn     (resetn),
        .i_data     (w_sb_in),
        .i_valid    (w_push),
        .o_ready_up (w_sb_ready),
        .o_data     (w_sb_out),
        .o_valid    (m_axis_tvalid),
        .i_ready_dn (m_axis_tready)
    );

    assign m_axis_tdata = w_sb_out[SB_W-1:2];
    assign m_axis_tlast = w_sb_out[1];
    assign m_axis_tid   = w_sb_out[0];

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Scoreboard bench for axis_packet_arbiter.
// Truncation scenario runs when PKT_ARB_MAXLEN_EN is defined.
module tb_axis_packet_arbiter;

    localparam int DW = 32;
`ifdef PKT_ARB_MAXLEN_EN
    localparam int MAXB      = 4;
    localparam bit MAXLEN_ON = 1'b1;
`else
    localparam int MAXB      = 256;
    localparam bit MAXLEN_ON = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic          id;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] s0_tdata = '0;
    logic          s0_tlast = 1'b0;
    logic          s0_tvalid = 1'b0;
    logic          s0_tready;
    logic [DW-1:0] s1_tdata = '0;
    logic          s1_tlast = 1'b0;
    logic          s1_tvalid = 1'b0;
    logic          s1_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic [0:0]    m_tid;
    logic          m_tvalid;
    logic          m_tready = 1'b0;

    exp_t   sb[$];
    logic   start_tids[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    bit     lat_chk = 1'b0;
    bit     bub_chk = 1'b0;
    bit     tog = 1'b0;

    bit            in_pkt = 1'b0;
    logic          cur_tid = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_d = '0;
    int            gap = 0;
    bit            seen_last = 1'b0;
    exp_t          mon_e;

    axis_packet_arbiter #(
        .TDATA_WIDTH (DW),
        .MAX_BEATS   (MAXB)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .s0_axis_tdata  (s0_tdata),
        .s0_axis_tlast  (s0_tlast),
        .s0_axis_tvalid (s0_tvalid),
        .s0_axis_tready (s0_tready),
        .s1_axis_tdata  (s1_tdata),
        .s1_axis_tlast  (s1_tlast),
        .s1_axis_tvalid (s1_tvalid),
        .s1_axis_tready (s1_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tlast   (m_tlast),
        .m_axis_tid     (m_tid),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops scoreboard on every handshake
    always @(negedge clk) begin
        if (!resetn) begin
            in_pkt     = 1'b0;
            prev_stall = 1'b0;
            gap        = 0;
            seen_last  = 1'b0;
        end else begin
            chk("tready_excl", 64'(s0_tready & s1_tready), 0);
            if (prev_stall)
                chk("stall_hold", {m_tvalid, m_tdata}, {1'b1, prev_d});
            if (!m_tvalid) gap++;
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("tdata", m_tdata, mon_e.d);
                    chk("tlast", m_tlast, mon_e.l);
                    chk("tid", m_tid, mon_e.id);
                    if (lat_chk)
                        chk("latency", 64'(cyc - mon_e.cyc), 0);
                end
                if (in_pkt) begin
                    chk("no_interleave", m_tid, cur_tid);
                end else begin
                    start_tids.push_back(m_tid[0]);
                    if (bub_chk && seen_last)
                        chk("bubble", 64'(gap >= 1), 1);
                end
                in_pkt  = !m_tlast;
                cur_tid = m_tid[0];
                if (m_tlast) begin
                    seen_last = 1'b1;
                    gap       = 0;
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_d     = m_tdata;
        end
    end

    task automatic drive(input int src, input logic [DW-1:0] d,
                         input logic l, input logic v);
        if (src == 0) begin
            s0_tdata = d; s0_tlast = l; s0_tvalid = v;
        end else begin
            s1_tdata = d; s1_tlast = l; s1_tvalid = v;
        end
    endtask

    task automatic send_beat(input int src, input logic [DW-1:0] d,
                             input logic l, input int idx);
        int   t;
        bit   acc;
        exp_t e;
        t   = 0;
        acc = 1'b0;
        drive(src, d, l, 1'b1);
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = (src == 0) ? (s0_tready === 1'b1) : (s1_tready === 1'b1);
            t++;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            chk("accept_timeout", 0, 1);
        end else if (!MAXLEN_ON || idx < MAXB) begin
            e.d   = d;
            e.l   = l || (MAXLEN_ON && idx == MAXB - 1);
            e.id  = (src != 0);
            e.cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic send_pkt(input int src, input int n,
                            input logic [DW-1:0] base);
        for (int i = 0; i < n; i++)
            send_beat(src, base + DW'(i), (i == n - 1), i);
    endtask

    task automatic reset_dut();
        resetn    = 1'b0;
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && sb.size() != 0; t++)
            @(negedge clk);
        chk("sb_drain", 64'(sb.size()), 0);
    endtask

    initial begin
        reset_dut();
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_tid", m_tid, 0);
        chk("rst_s0_tready", s0_tready, 0);
        chk("rst_s1_tready", s1_tready, 0);

        // idle inputs
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_tvalid", m_tvalid, 0);
            chk("idle_s0_tready", s0_tready, 0);
            chk("idle_s1_tready", s1_tready, 0);
        end

        // single s0 packet, full-rate sink
        @(posedge clk); #1;
        m_tready = 1'b1;
        lat_chk  = 1'b1;
        send_pkt(0, 4, 32'hA0);
        s0_tvalid = 1'b0;
        drain();

        // both inputs busy: round-robin, packet-atomic
        reset_dut();
        lat_chk = 1'b1;
        bub_chk = 1'b1;
        start_tids.delete();
        fork
            for (int p = 0; p < 3; p++) send_pkt(0, 3, 32'hC0 + 32'(p * 16));
            for (int p = 0; p < 3; p++) send_pkt(1, 3, 32'hD0 + 32'(p * 16));
        join
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        drain();
        chk("rr_count", 64'(start_tids.size()), 6);
        for (int k = 0; k < 6; k++)
            chk("rr_order", start_tids[k], 64'(k % 2));

        // toggling backpressure on an 8-beat s1 packet
        lat_chk = 1'b0;
        bub_chk = 1'b0;
        tog     = 1'b1;
        fork
            begin
                send_pkt(1, 8, 32'hE0);
                s1_tvalid = 1'b0;
                tog = 1'b0;
            end
            begin
                while (tog) begin
                    @(posedge clk);
                    #1 m_tready = ~m_tready;
                end
            end
        join
        m_tready = 1'b1;
        drain();

        // reset in the middle of beat 3 of a 6-beat s0 packet
        reset_dut();
        send_beat(0, 32'hB0, 1'b0, 0);
        send_beat(0, 32'hB1, 1'b0, 1);
        drive(0, 32'hB2, 1'b0, 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_tvalid", m_tvalid, 0);
        chk("midrst_tdata", m_tdata, 0);
        chk("midrst_tlast", m_tlast, 0);
        chk("midrst_tid", m_tid, 0);
        chk("midrst_s0_tready", s0_tready, 0);
        chk("midrst_s1_tready", s1_tready, 0);
        s0_tvalid = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        send_pkt(1, 3, 32'hF0);
        s1_tvalid = 1'b0;
        drain();

`ifdef PKT_ARB_MAXLEN_EN
        // oversize packet is truncated, exact-size one is untouched
        send_pkt(0, 7, 32'h60);
        s0_tvalid = 1'b0;
        send_pkt(1, 2, 32'h70);
        s1_tvalid = 1'b0;
        send_pkt(0, 4, 32'h80);
        s0_tvalid = 1'b0;
        drain();
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
